// File: rtl/oflow_if_pkg.sv
// Shared types, default widths and helpers for the MEM buffer / PE stream interface.
package oflow_if_pkg;

  localparam int FEAT_W_D = 142;
  localparam int ID_W_D   = 12;
  localparam int HIST_W_D = 3;
  localparam int FPW_D    = 2;
  localparam int GROUP_D  = 4;
  localparam int PE_NUM_D = 24;
  localparam int ROW_W_D  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } wr_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // History counter sits between the feature payload and the ID field.
  function automatic logic [FEAT_W_D+HIST_W_D-1:0] insert_hist(
    input logic [FEAT_W_D-1:0] rec,
    input logic [HIST_W_D-1:0] hist
  );
    return {rec[FEAT_W_D-1:ID_W_D], hist, rec[ID_W_D-1:0]};
  endfunction

endpackage

// File: rtl/oflow_if_word_packer.sv
// Selects the records for one buffer word from the group snapshot; slots past n are zero.
module oflow_if_word_packer
  import oflow_if_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_D,
  parameter int FPW    = FPW_D,
  parameter int GROUP  = GROUP_D,
  parameter int CNT_W  = 3
) (
  input  logic [GROUP*FEAT_W-1:0] snap,
  input  logic [CNT_W-1:0]        n,
  input  logic [CNT_W-1:0]        word_idx,
  output logic [FPW*FEAT_W-1:0]   word
);

  always_comb begin
    word = '0;
    for (int s = 0; s < FPW; s++) begin
      for (int g = 0; g < GROUP; g++) begin
        if ((int'(word_idx) * FPW + s == g) && (g < int'(n)))
          word[FPW*FEAT_W-1-s*FEAT_W -: FEAT_W] = snap[g*FEAT_W +: FEAT_W];
      end
    end
  end

endmodule

// File: rtl/oflow_interface_mem_pe_stream.sv
// Write path packs a PE group into buffer words; read path splits words into PE records.
// Optional perf counters are compiled in with OFLOW_IF_PERF_CNT_EN.
module oflow_interface_mem_pe_stream
  import oflow_if_pkg::*;
#(
  parameter int FEAT_W = FEAT_W_D,
  parameter int ID_W   = ID_W_D,
  parameter int HIST_W = HIST_W_D,
  parameter int FEATS_PER_WORD = FPW_D,
  parameter int GROUP  = GROUP_D,
  parameter int PE_NUM = PE_NUM_D,
  parameter int ROW_W  = ROW_W_D,
  localparam int DATA_W = FEATS_PER_WORD * FEAT_W,
  localparam int PE_W   = FEAT_W + HIST_W,
  localparam int SEL_W  = $clog2(PE_NUM / GROUP),
  localparam int REM_W  = $clog2(GROUP),
  localparam int CNT_W  = $clog2(GROUP + 1)
) (
  input  logic                           clk,
  input  logic                           reset_N,
  input  logic                           wr_start,
  input  logic [SEL_W-1:0]               pe_sel,
  input  logic [REM_W-1:0]               remainder,
  input  logic [ROW_W-1:0]               row_base,
  input  logic [PE_NUM*FEAT_W-1:0]       data_out_pe,
  output logic                           wr_valid,
  input  logic                           wr_ready,
  output logic [DATA_W-1:0]              wr_data,
  output logic [ROW_W-1:0]               wr_row,
  output logic                           wr_busy,
  output logic                           wr_done,
  input  logic                           rd_valid,
  output logic                           rd_ready,
  input  logic [DATA_W-1:0]              rd_data,
  input  logic [HIST_W-1:0]              rd_hist,
  input  logic                           rd_last,
  output logic                           pe_valid,
  input  logic                           pe_ready,
  output logic [FEATS_PER_WORD*PE_W-1:0] pe_data,
  output logic                           pe_last,
  output logic [15:0]                    perf_wr_words,
  output logic [15:0]                    perf_rd_stall
);

  // valid/ready: a word moves on a rising edge where valid && ready; the source
  // holds valid and data stable until then.
  wr_state_t               state;
  logic [GROUP*FEAT_W-1:0] snap;
  logic [CNT_W-1:0]        n_rec, words, word_idx, n_next;

  assign n_next  = (remainder == '0) ? CNT_W'(GROUP) : CNT_W'(remainder);
  assign wr_busy = (state == SEND);

  always_ff @(posedge clk) begin
    if (reset_N) begin
      state    <= IDLE;
      snap     <= '0;
      n_rec    <= '0;
      words    <= '0;
      word_idx <= '0;
      wr_row   <= '0;
      wr_valid <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_start) begin
            snap     <= data_out_pe[int'(pe_sel)*GROUP*FEAT_W +: GROUP*FEAT_W];
            n_rec    <= n_next;
            words    <= CNT_W'(ceil_div(int'(n_next), FEATS_PER_WORD));
            word_idx <= '0;
            wr_row   <= row_base;
            wr_valid <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          if (wr_ready) begin
            word_idx <= word_idx + CNT_W'(1);
            wr_row   <= wr_row + ROW_W'(1);
            if (word_idx == words - CNT_W'(1)) begin
              wr_valid <= 1'b0;
              wr_done  <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  oflow_if_word_packer #(
    .FEAT_W (FEAT_W),
    .FPW    (FEATS_PER_WORD),
    .GROUP  (GROUP),
    .CNT_W  (CNT_W)
  ) u_packer (
    .snap     (snap),
    .n        (n_rec),
    .word_idx (word_idx),
    .word     (wr_data)
  );

  // Single skid-free output register: refill in the same cycle the PEs drain it.
  assign rd_ready = !pe_valid || pe_ready;

  always_ff @(posedge clk) begin
    if (reset_N) begin
      pe_valid <= 1'b0;
      pe_last  <= 1'b0;
      pe_data  <= '0;
    end else if (rd_valid && rd_ready) begin
      pe_valid <= 1'b1;
      pe_last  <= rd_last;
      for (int s = 0; s < FEATS_PER_WORD; s++) begin
        pe_data[FEATS_PER_WORD*PE_W-1-s*PE_W -: PE_W] <= {
          rd_data[DATA_W-1-s*FEAT_W -: FEAT_W-ID_W],
          rd_hist,
          rd_data[DATA_W-1-s*FEAT_W-(FEAT_W-ID_W) -: ID_W]
        };
      end
    end else if (pe_ready) begin
      pe_valid <= 1'b0;
      pe_last  <= 1'b0;
    end
  end

`ifdef OFLOW_IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset_N) begin
      perf_wr_words <= '0;
      perf_rd_stall <= '0;
    end else begin
      if (wr_valid && wr_ready && perf_wr_words != 16'hFFFF)
        perf_wr_words <= perf_wr_words + 16'd1;
      if (pe_valid && !pe_ready && perf_rd_stall != 16'hFFFF)
        perf_rd_stall <= perf_rd_stall + 16'd1;
    end
  end
`else
  assign perf_wr_words = '0;
  assign perf_rd_stall = '0;
`endif

endmodule

// File: tb/tb_oflow_interface_mem_pe_stream.sv
// Self-checking bench for oflow_interface_mem_pe_stream: write bursts and read stream
// are scoreboarded against expectations computed from the stimulus.
module tb_oflow_interface_mem_pe_stream;

  localparam int FEAT_W = 142;
  localparam int DATA_W = 284;
  localparam int PE_W   = 145;
  localparam int PE_DW  = 290;
  localparam int ROW_W  = 6;

  logic                   clk = 1'b0;
  logic                   reset_N;
  logic                   wr_start;
  logic [2:0]             pe_sel;
  logic [1:0]             remainder;
  logic [ROW_W-1:0]       row_base;
  logic [24*FEAT_W-1:0]   data_out_pe;
  logic                   wr_valid, wr_ready, wr_busy, wr_done;
  logic [DATA_W-1:0]      wr_data;
  logic [ROW_W-1:0]       wr_row;
  logic                   rd_valid, rd_ready, rd_last;
  logic [DATA_W-1:0]      rd_data;
  logic [2:0]             rd_hist;
  logic                   pe_valid, pe_ready, pe_last;
  logic [PE_DW-1:0]       pe_data;
  logic [15:0]            perf_wr_words, perf_rd_stall;

  logic [FEAT_W-1:0]         recs[24];
  logic [ROW_W+DATA_W-1:0]   exp_q[$];
  logic [PE_DW:0]            rd_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  oflow_interface_mem_pe_stream dut (
    .clk(clk), .reset_N(reset_N), .wr_start(wr_start), .pe_sel(pe_sel),
    .remainder(remainder), .row_base(row_base), .data_out_pe(data_out_pe),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_row(wr_row),
    .wr_busy(wr_busy), .wr_done(wr_done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_hist(rd_hist), .rd_last(rd_last), .pe_valid(pe_valid),
    .pe_ready(pe_ready), .pe_data(pe_data), .pe_last(pe_last),
    .perf_wr_words(perf_wr_words), .perf_rd_stall(perf_rd_stall)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    reset_N = 1'b1;
    wr_start = 0; pe_sel = 0; remainder = 0; row_base = 0; wr_ready = 0;
    rd_valid = 0; rd_data = '0; rd_hist = 0; rd_last = 0; pe_ready = 1;
    exp_q.delete(); rd_q.delete();
    repeat (2) @(negedge clk);
    reset_N = 1'b0;
  endtask

  function automatic logic [FEAT_W-1:0] rand_rec();
    logic [159:0] t;
    for (int i = 0; i < 5; i++) t[i*32 +: 32] = $urandom;
    return t[FEAT_W-1:0];
  endfunction

  task automatic load_recs();
    for (int k = 0; k < 24; k++) begin
      recs[k] = rand_rec();
      data_out_pe[k*FEAT_W +: FEAT_W] = recs[k];
    end
  endtask

  function automatic logic [DATA_W-1:0] exp_word(input int sel, input int n, input int w);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int s = 0; s < 2; s++)
      if (w*2 + s < n) r[DATA_W-1-s*FEAT_W -: FEAT_W] = recs[sel*4 + w*2 + s];
    return r;
  endfunction

  function automatic logic [PE_DW-1:0] exp_pe(input logic [DATA_W-1:0] d, input logic [2:0] h);
    logic [PE_DW-1:0] r;
    logic [FEAT_W-1:0] slot;
    for (int s = 0; s < 2; s++) begin
      slot = d[DATA_W-1-s*FEAT_W -: FEAT_W];
      r[PE_DW-1-s*PE_W -: PE_W] = {slot[141:12], h, slot[11:0]};
    end
    return r;
  endfunction

  // Starts at a negedge; ends at the negedge where wr_done is expected high.
  task automatic run_burst(input int sel, input int rem, input int rowb,
                           input int stall_w, input int stall_n, input bit chain);
    int n, words, w, st, cyc;
    logic [ROW_W+DATA_W-1:0] e;
    n = (rem == 0) ? 4 : rem;
    words = (n + 1) / 2;
    for (int k = 0; k < words; k++)
      exp_q.push_back({ROW_W'(rowb + k), exp_word(sel, n, k)});
    wr_start = 1; pe_sel = 3'(sel); remainder = 2'(rem); row_base = ROW_W'(rowb); wr_ready = 0;
    @(negedge clk);
    wr_start = 0;
    load_recs();
    n_checks++;
    if (wr_busy !== 1'b1 || wr_done !== 1'b0) begin
      n_fail++; $display("FAIL wr_start: busy=%b done=%b, want busy=1 done=0", wr_busy, wr_done);
    end
    w = 0; st = 0; cyc = 0;
    while (w < words && cyc < 64) begin
      e = exp_q[0];
      n_checks++;
      if (wr_valid !== 1'b1 || {wr_row, wr_data} !== e) begin
        n_fail++;
        $display("FAIL wr_word%0d: valid=%b row=%0d data=%h, want valid=1 row=%0d data=%h",
                 w, wr_valid, wr_row, wr_data, e[ROW_W+DATA_W-1 -: ROW_W], e[DATA_W-1:0]);
      end
      if (w == stall_w && st < stall_n) begin
        wr_ready = 0; wr_start = 1; pe_sel = 3'(5 - sel); st++;
      end else begin
        wr_ready = 1; wr_start = 0;
        void'(exp_q.pop_front());
        w++;
      end
      @(negedge clk);
      cyc++;
    end
    wr_ready = 0; wr_start = 0;
    n_checks++;
    if (w < words) begin
      n_fail++; $display("FAIL wr_timeout: words=%0d, want %0d", w, words);
    end
    n_checks++;
    if (wr_done !== 1'b1 || wr_valid !== 1'b0 || wr_busy !== 1'b0) begin
      n_fail++; $display("FAIL wr_done: done=%b valid=%b busy=%b, want 1 0 0", wr_done, wr_valid, wr_busy);
    end
    if (!chain) begin
      @(negedge clk);
      n_checks++;
      if (wr_done !== 1'b0) begin
        n_fail++; $display("FAIL wr_done_pulse: done=%b, want 0", wr_done);
      end
    end
  endtask

  // One read-side cycle; starts and ends at a negedge.
  task automatic rd_step(input bit v, input logic [DATA_W-1:0] d, input logic [2:0] h,
                         input bit last, input bit rdy);
    bit held, accept;
    rd_valid = v; rd_data = d; rd_hist = h; rd_last = last; pe_ready = rdy;
    #1;
    held = (rd_q.size() != 0);
    accept = v && (!held || rdy);
    n_checks++;
    if (pe_valid !== held || rd_ready !== (!held || rdy)) begin
      n_fail++; $display("FAIL rd_hs: pe_valid=%b rd_ready=%b, want %b %b", pe_valid, rd_ready, held, !held || rdy);
    end
    if (held) begin
      n_checks++;
      if ({pe_last, pe_data} !== rd_q[0]) begin
        n_fail++; $display("FAIL pe_data: last=%b data=%h, want last=%b data=%h",
                           pe_last, pe_data, rd_q[0][PE_DW], rd_q[0][PE_DW-1:0]);
      end
      if (rdy) void'(rd_q.pop_front());
    end
    if (accept) rd_q.push_back({last, exp_pe(d, h)});
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({wr_valid, wr_busy, wr_done, pe_valid, pe_last} !== 5'b0 || wr_row !== '0 ||
        wr_data !== '0 || pe_data !== '0 || perf_wr_words !== 16'd0 || perf_rd_stall !== 16'd0) begin
      n_fail++; $display("FAIL reset: wv=%b busy=%b done=%b pv=%b pl=%b row=%0d, want all 0",
                         wr_valid, wr_busy, wr_done, pe_valid, pe_last, wr_row);
    end
    n_checks++;
    if (rd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_rd_ready: got %b, want 1", rd_ready);
    end
  endtask

  task automatic test_write();
    load_recs();
    run_burst(2, 0, 5, -1, 0, 1'b0);
    run_burst(0, 3, 20, 1, 3, 1'b0);
    run_burst(1, 1, 63, -1, 0, 1'b0);
    run_burst(5, 0, 63, -1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_burst(3, 2, 10, -1, 0, 1'b1);
    run_burst(4, 0, 30, 0, 1, 1'b0);
  endtask

  task automatic test_read();
    logic [FEAT_W-1:0] a, b;
    a = rand_rec(); b = rand_rec();
    rd_step(1, {a, b}, 3'd5, 1, 0);
    rd_step(1, {b, a}, 3'd1, 0, 0);
    n_checks++;
    if (pe_data[159:157] !== 3'd5 || pe_data[14:12] !== 3'd5 || pe_last !== 1'b1) begin
      n_fail++; $display("FAIL pe_hist: hist0=%0d hist1=%0d last=%b, want 5 5 1",
                         pe_data[159:157], pe_data[14:12], pe_last);
    end
    rd_step(0, '0, 0, 0, 1);
    rd_step(0, '0, 0, 0, 1);
  endtask

  task automatic test_read_stream();
    int cyc;
    for (int i = 0; i < 40; i++)
      rd_step(1'($urandom_range(0, 1)), {rand_rec(), rand_rec()}, 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
    cyc = 0;
    while (rd_q.size() != 0 && cyc < 10) begin
      rd_step(0, '0, 0, 0, 1);
      cyc++;
    end
    n_checks++;
    if (rd_q.size() != 0) begin
      n_fail++; $display("FAIL rd_drain: %0d words pending, want 0", rd_q.size());
    end
  endtask

  task automatic test_reset_mid();
    rd_step(1, {rand_rec(), rand_rec()}, 3'd2, 1, 0);
    wr_start = 1; pe_sel = 1; remainder = 0; row_base = 10; wr_ready = 0; pe_ready = 0;
    @(negedge clk);
    wr_start = 0; wr_ready = 1; reset_N = 1;
    @(negedge clk);
    reset_N = 0; wr_ready = 0; pe_ready = 1;
    rd_q.delete();
    n_checks++;
    if (wr_valid !== 1'b0 || wr_busy !== 1'b0 || wr_done !== 1'b0 || pe_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: wv=%b busy=%b done=%b pv=%b, want 0 0 0 0",
                         wr_valid, wr_busy, wr_done, pe_valid);
    end
    @(negedge clk);
    n_checks++;
    if (wr_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_done: done=%b, want 0", wr_done);
    end
    run_burst(1, 3, 40, -1, 0, 1'b0);
  endtask

  task automatic test_perf();
    logic [15:0] exp_w, exp_s;
    do_reset();
    run_burst(2, 0, 0, -1, 0, 1'b0);
    run_burst(3, 1, 2, -1, 0, 1'b0);
    rd_step(1, {rand_rec(), rand_rec()}, 3'd3, 0, 0);
    for (int i = 0; i < 4; i++) rd_step(0, '0, 0, 0, 0);
    rd_step(0, '0, 0, 0, 1);
`ifdef OFLOW_IF_PERF_CNT_EN
    exp_w = 16'd3; exp_s = 16'd4;
`else
    exp_w = 16'd0; exp_s = 16'd0;
`endif
    n_checks++;
    if (perf_wr_words !== exp_w || perf_rd_stall !== exp_s) begin
      n_fail++; $display("FAIL perf: wr_words=%0d rd_stall=%0d, want %0d %0d",
                         perf_wr_words, perf_rd_stall, exp_w, exp_s);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_read();
    test_read_stream();
    test_reset_mid();
    test_perf();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/oflow_interface_mem_pe_stream.md
Name: oflow_interface_mem_pe_stream

Overview:
- Parametrised, handshaked successor of the memory-buffer/PE interface.
- Write path: snapshots one group of PE feature records, packs FEATS_PER_WORD records per buffer word and streams the words to the MEM buffer over several cycles, with zero padding on the final partial word.
- Read path: accepts buffer words, splits each word into FEATS_PER_WORD PE records, inserts the history-frame counter into each record, and presents them to the PEs through a registered valid/ready stage.

Parameters:
- FEAT_W, 142: stored feature record width (no d_history field).
- ID_W, 12: ID field width, the LSBs of a record.
- HIST_W, 3: history-frame counter width.
- FEATS_PER_WORD, 2: records per buffer word; DATA_W = FEATS_PER_WORD*FEAT_W.
- GROUP, 4: records per pe_sel group.
- PE_NUM, 24: PE count; must be a multiple of GROUP.
- ROW_W, 6: buffer row address width.

Ports:
- clk  in  1  clock, rising edge.
- reset_N  in  1  synchronous reset, active-high (1 = reset).
- wr_start  in  1  start packing one group; sampled in IDLE only.
- pe_sel  in  $clog2(PE_NUM/GROUP)  group index.
- remainder  in  $clog2(GROUP)  valid records in group; 0 means GROUP.
- row_base  in  ROW_W  first buffer row of the burst.
- data_out_pe  in  PE_NUM x FEAT_W  PE result records.
- wr_valid  out  1  buffer write word valid.
- wr_ready  in  1  buffer accepts the word.
- wr_data  out  DATA_W  packed word; slot 0 in the MSBs.
- wr_row  out  ROW_W  row for wr_data.
- wr_busy  out  1  write FSM not IDLE.
- wr_done  out  1  one-cycle pulse after the last word is accepted.
- rd_valid  in  1  buffer read word valid.
- rd_ready  out  1  interface accepts the read word.
- rd_data  in  DATA_W  buffer word.
- rd_hist  in  HIST_W  counter_of_history_frame for this word.
- rd_last  in  1  last word of the read burst (done_read).
- pe_valid  out  1  PE output valid.
- pe_ready  in  1  PEs accept the output.
- pe_data  out  FEATS_PER_WORD x (FEAT_W+HIST_W)  records for the PEs.
- pe_last  out  1  rd_last registered alongside its word.
- perf_wr_words  out  16  see Optional Feature.
- perf_rd_stall  out  16  see Optional Feature.

Behaviour:
- Reset values: every output 0; FSM in IDLE; snapshot and output registers cleared. Reset asserted mid-burst discards the in-flight group and any pending PE word.
- Write FSM has two states, IDLE and SEND.
  - IDLE with wr_start=1: capture data_out_pe[pe_sel*GROUP +: GROUP] into the snapshot.
  - Same cycle: n = (remainder==0 ? GROUP : remainder), words = ceil(n/FEATS_PER_WORD), word index = 0, wr_row = row_base; go to SEND.
- SEND:
  - wr_valid=1; wr_data and wr_row are held stable while wr_ready=0.
  - On handshake, word index+1 and wr_row+1, wrapping modulo 2^ROW_W.
  - Handshake on the last word: go to IDLE; wr_done=1 in the next cycle.
- Slot s of word w carries record w*FEATS_PER_WORD+s when that index < n; otherwise all zeros.
- wr_start while busy is ignored. wr_start in the cycle wr_done is high is accepted, because the FSM is already in IDLE.
- The snapshot isolates the burst from data_out_pe changes after capture.
- Read path is a single output register.
  - rd_ready = !pe_valid || pe_ready.
  - On rd_valid && rd_ready: load pe_data, set pe_valid=1, pe_last=rd_last.
  - Else if pe_ready: clear pe_valid and pe_last.
- Read latency is 1 cycle; full throughput when pe_ready is held high.
- Record split: slot s = rd_data[DATA_W-1-s*FEAT_W -: FEAT_W]. PE record = {slot[FEAT_W-1:ID_W], rd_hist, slot[ID_W-1:0]}.
- Read and write paths are independent and may be active in the same cycle.

Optional Feature:
- Macro: OFLOW_IF_PERF_CNT_EN.
- Defined:
  - perf_wr_words counts write handshakes.
  - perf_rd_stall counts cycles with pe_valid && !pe_ready.
  - Both are 16-bit, saturate at 0xFFFF and clear on reset.
- Undefined: both outputs are constant 0 and no counter logic is compiled.

Decomposition:
- Package oflow_if_pkg: FSM state enum (IDLE, SEND), default widths, function ceil_div, function insert_hist(record, hist).
- One sub-module: oflow_if_word_packer, a combinational slot select with zero padding, instantiated once in the write path.

Test Plan:
- Full group, GROUP=4, remainder=0, pe_sel=2, row_base=5, wr_ready=1 → 2 words, rows 5 and 6; records 8|9 then 10|11; wr_done 1 cycle after the second handshake.
- remainder=3, pe_sel=0, wr_ready low 3 cycles on word 1 → word 1 = rec2 | 0; data and row held stable during the stall; 2 words total.
- remainder=1, row_base=63 → one word {rec0, zeros} at row 63; a second burst from row_base=63 with remainder=0 wraps wr_row to 0.
- Read word {A,B}, rd_hist=5, rd_last=1, pe_ready=0 for 2 cycles → pe_valid held with rd_ready=0; pe_data = {A_hi,3'd5,A_id} / {B_hi,3'd5,B_id}; pe_last=1.
- Reset asserted during SEND word 0 → next cycle wr_valid=0 and wr_busy=0; no wr_done; a new wr_start is accepted.
- With OFLOW_IF_PERF_CNT_EN, 3 write handshakes and 4 read-stall cycles → perf_wr_words=3, perf_rd_stall=4; without the macro, both read 0.
